// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-754 adder/subtractor. One operation at a time: operands are
// accepted in IDLE, walk through ALIGN/COMP/ADD/NORM/ROUND (or bypass straight
// to DONE for zero/inf/NaN operands), and the result is held in DONE until the
// consumer takes it. Denormal inputs are flushed to zero; rounding is RNE.
module fp_addsub_seq #(
   parameter int SIG_BITS = 23,
   parameter int EXP_BITS = 8,
   localparam int W = 1 + EXP_BITS + SIG_BITS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         busy
);

   // Extended mantissa {hidden, fraction, G, R, S} and shift counter widths
   localparam int M  = SIG_BITS + 4;
   localparam int CW = $clog2(M + 1);

   localparam logic [EXP_BITS-1:0] M_E      = EXP_BITS'(M);
   localparam logic [CW-1:0]       CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [EXP_BITS:0]   E_ONE    = {{EXP_BITS{1'b0}}, 1'b1};
   localparam logic [EXP_BITS:0]   E_MAX    = {1'b0, {EXP_BITS{1'b1}}};
   localparam logic [M-1:0]        M_ONE    = {{(M-1){1'b0}}, 1'b1};
   localparam logic [W-1:0]        QNAN     = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(SIG_BITS-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ALIGN, COMP, ADD, NORM, ROUND, DONE} state_t;

   state_t              state_reg, state_next;
   logic [M-1:0]        mant_a_reg, mant_a_next;
   logic [M-1:0]        mant_b_reg, mant_b_next;
   logic [M:0]          sum_reg, sum_next;
   logic [EXP_BITS:0]   exp_reg, exp_next;
   logic                sign_reg, sign_next;
   logic                eff_sub_reg, eff_sub_next;
   logic [CW-1:0]       shift_cnt_reg, shift_cnt_next;
   logic [W-1:0]        result_reg, result_next;

   // Operand decode at the accept point
   logic                sign_a, sign_b_eff;
   logic [EXP_BITS-1:0] exp_a, exp_b, exp_big, exp_small, exp_diff;
   logic [SIG_BITS-1:0] frac_a, frac_b, frac_big, frac_small;
   logic                a_ones, b_ones, a_zero, b_zero, a_nan, b_nan;
   logic                swap, special, sign_big;
   logic [W-1:0]        bypass_res;

   assign sign_a     = op_a[W-1];
   assign sign_b_eff = op_b[W-1] ^ sub;
   assign exp_a      = op_a[W-2:SIG_BITS];
   assign exp_b      = op_b[W-2:SIG_BITS];
   assign frac_a     = op_a[SIG_BITS-1:0];
   assign frac_b     = op_b[SIG_BITS-1:0];
   assign a_ones     = &exp_a;
   assign b_ones     = &exp_b;
   assign a_zero     = ~|exp_a;
   assign b_zero     = ~|exp_b;
   assign a_nan      = a_ones & (|frac_a);
   assign b_nan      = b_ones & (|frac_b);
   assign special    = a_ones | b_ones | a_zero | b_zero;

   // Larger magnitude always goes to A; ties keep the original order
   assign swap       = op_b[W-2:0] > op_a[W-2:0];
   assign exp_big    = swap ? exp_b : exp_a;
   assign exp_small  = swap ? exp_a : exp_b;
   assign frac_big   = swap ? frac_b : frac_a;
   assign frac_small = swap ? frac_a : frac_b;
   assign sign_big   = swap ? sign_b_eff : sign_a;
   assign exp_diff   = exp_big - exp_small;

   // Result for operands that never enter the arithmetic path
   always_comb begin
      bypass_res = {sign_a, op_a[W-2:0]};
      if (a_nan || b_nan)
         bypass_res = QNAN;
      else if (a_ones && b_ones)
         bypass_res = (sign_a != sign_b_eff) ? QNAN : {sign_a, op_a[W-2:0]};
      else if (a_ones)
         bypass_res = {sign_a, op_a[W-2:0]};
      else if (b_ones)
         bypass_res = {sign_b_eff, op_b[W-2:0]};
      else if (a_zero && b_zero)
         bypass_res = {sign_a & sign_b_eff, {(W-1){1'b0}}};
      else if (a_zero)
         bypass_res = {sign_b_eff, op_b[W-2:0]};
   end

   // Datapath helpers for ADD and ROUND
   logic [M:0]          sum_add, sum_eff;
   logic [M-1:0]        rnd_m;
   logic                round_up, rnd_carry;
   logic [SIG_BITS+1:0] mant_rnd;
   logic [EXP_BITS:0]   exp_rnd;
   logic [SIG_BITS-1:0] frac_rnd;

   assign sum_add   = {1'b0, mant_a_reg} + {1'b0, mant_b_reg};
   assign sum_eff   = eff_sub_reg ? {1'b0, sum_add[M-1:0]} : sum_add;
   assign rnd_m     = sum_reg[M-1:0];
   assign round_up  = rnd_m[2] & (rnd_m[1] | rnd_m[0] | rnd_m[3]);
   assign mant_rnd  = {1'b0, rnd_m[M-1:3]} + {{(SIG_BITS+1){1'b0}}, round_up};
   assign rnd_carry = mant_rnd[SIG_BITS+1];
   assign exp_rnd   = rnd_carry ? exp_reg + E_ONE : exp_reg;
   assign frac_rnd  = rnd_carry ? mant_rnd[SIG_BITS:1] : mant_rnd[SIG_BITS-1:0];

   // Next-state and datapath update for every state
   always_comb begin
      state_next     = state_reg;
      mant_a_next    = mant_a_reg;
      mant_b_next    = mant_b_reg;
      sum_next       = sum_reg;
      exp_next       = exp_reg;
      sign_next      = sign_reg;
      eff_sub_next   = eff_sub_reg;
      shift_cnt_next = shift_cnt_reg;
      result_next    = result_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               if (special) begin
                  result_next = bypass_res;
                  state_next  = DONE;
               end else begin
                  mant_a_next    = {1'b1, frac_big, 3'b000};
                  mant_b_next    = {1'b1, frac_small, 3'b000};
                  exp_next       = {1'b0, exp_big};
                  sign_next      = sign_big;
                  eff_sub_next   = sign_a ^ sign_b_eff;
                  shift_cnt_next = (exp_diff >= M_E) ? CW'(M) : exp_diff[CW-1:0];
                  state_next     = ALIGN;
               end
            end
         end
         ALIGN: begin
            if (shift_cnt_reg != '0) begin
               mant_b_next    = {1'b0, mant_b_reg[M-1:2], mant_b_reg[1] | mant_b_reg[0]};
               shift_cnt_next = shift_cnt_reg - CNT_ONE;
            end
            if (shift_cnt_reg <= CNT_ONE)
               state_next = COMP;
         end
         COMP: begin
            if (eff_sub_reg)
               mant_b_next = ~mant_b_reg + M_ONE;
            state_next = ADD;
         end
         ADD: begin
            if (sum_eff == '0) begin
               result_next = '0;
               state_next  = DONE;
            end else begin
               sum_next   = sum_eff;
               state_next = NORM;
            end
         end
         NORM: begin
            if (sum_reg[M]) begin
               sum_next   = {1'b0, sum_reg[M:2], sum_reg[1] | sum_reg[0]};
               exp_next   = exp_reg + E_ONE;
               state_next = ROUND;
            end else if (sum_reg[M-1]) begin
               state_next = ROUND;
            end else begin
               sum_next = {sum_reg[M-1:0], 1'b0};
               exp_next = exp_reg - E_ONE;
               if (exp_reg == E_ONE) begin
                  result_next = {sign_reg, {(W-1){1'b0}}};
                  state_next  = DONE;
               end else if (sum_reg[M-2]) begin
                  state_next = ROUND;
               end
            end
         end
         ROUND: begin
            exp_next = exp_rnd;
            if (exp_rnd >= E_MAX)
               result_next = {sign_reg, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}};
            else
               result_next = {sign_reg, exp_rnd[EXP_BITS-1:0], frac_rnd};
            state_next = DONE;
         end
         DONE: begin
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mant_a_reg    <= '0;
         mant_b_reg    <= '0;
         sum_reg       <= '0;
         exp_reg       <= '0;
         sign_reg      <= 1'b0;
         eff_sub_reg   <= 1'b0;
         shift_cnt_reg <= '0;
         result_reg    <= '0;
      end else begin
         mant_a_reg    <= mant_a_next;
         mant_b_reg    <= mant_b_next;
         sum_reg       <= sum_next;
         exp_reg       <= exp_next;
         sign_reg      <= sign_next;
         eff_sub_reg   <= eff_sub_next;
         shift_cnt_reg <= shift_cnt_next;
         result_reg    <= result_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign result    = result_reg;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: hand-computed vectors, latency, bypass,
// backpressure and mid-operation reset.
module tb_fp_addsub_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   fp_addsub_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   // One operation: accept, wait for DONE (bounded), hold off out_ready for
   // 'hold' cycles, then hand the result over.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_res,
                         input logic exp_bypass, input int exp_lat, input int hold);
      int lat;
      logic [31:0] held;
      @(negedge clk);
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      op_a = a; op_b = b; sub = s; in_valid = 1'b1;
      @(posedge clk); #1;
      // garbage while busy must be ignored
      op_a = $urandom; op_b = $urandom; sub = 1'($urandom);
      check({tag, " bypass"}, 32'(out_valid), 32'(exp_bypass));
      lat = 0;
      while (!out_valid && lat < 400) begin
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      if (!out_valid)
         check({tag, " timeout"}, 32'(out_valid), 32'd1);
      if (exp_lat >= 0)
         check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, result, exp_res);
      held = result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
         check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
         check({tag, " hold result"}, result, held);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " released"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b0;
      #12;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset result", result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("1+1",        32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 5, 0);
      run_op("1-1",        32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 3, 0);
      run_op("tie",        32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, -1, 0);
      run_op("above_half", 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, -1, 0);
      run_op("3-1",        32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 5, 0);
      run_op("1-2",        32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, -1, 0);
      run_op("1-1ulp",     32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 1'b0, -1, 0);
      run_op("underflow",  32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, -1, 0);
      run_op("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, -1, 0);
      run_op("inf-inf",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b1, -1, 0);
      run_op("nan+1",      32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1, -1, 0);
      run_op("-inf+1",     32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b1, -1, 0);
      run_op("1+0",        32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 1'b1, -1, 0);
      run_op("0-1",        32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b1, -1, 0);
      run_op("-0+-0",      32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b1, -1, 0);
      run_op("0-0",        32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, -1, 0);
      run_op("backpressure", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 5, 3);

      // Reset in the middle of a long ALIGN (d = 24)
      @(negedge clk);
      op_a = 32'h3F800000; op_b = 32'h33800000; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy before", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst result", result, 32'h0);
      check("rst busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op("after_rst",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 5, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 SHALL have parameter SIG_BITS, default 23, meaning fraction width.
REQ-002 SHALL have parameter EXP_BITS, default 8, meaning exponent width; word width W = 1+EXP_BITS+SIG_BITS (32).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the operands are presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can accept; it is high only in IDLE.
REQ-007 SHALL have port op_a, input, W, meaning IEEE-754 operand A.
REQ-008 SHALL have port op_b, input, W, meaning IEEE-754 operand B.
REQ-009 SHALL have port sub, input, 1; 1 computes A-B and 0 computes A+B.
REQ-010 SHALL have port out_valid, output, 1, meaning the result is available; it is high only in DONE.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-012 SHALL have port result, output, W, meaning the IEEE-754 sum or difference.
REQ-013 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ALIGN, COMP, ADD, NORM, ROUND, DONE; each lasts 1 cycle unless stated otherwise.
REQ-015 SHALL accept operands on a clock edge where in_valid and in_ready are both high, latching op_a, op_b and sub.
REQ-016 SHALL apply effective B sign = sign(op_b) XOR sub.
REQ-017 SHALL swap operands at accept so A holds the larger magnitude (exponent, then fraction); result sign = sign of A.
REQ-018 SHALL hold each mantissa as a 27-bit extended value {hidden, fraction, G, R, S} (SIG_BITS+3:0).
REQ-019 SHALL treat exponent==0 operands (zero or denormal) as zero.
REQ-020 SHALL, when either operand is exponent-all-ones or zero, go IDLE->DONE on the accept edge (bypass):
  - any NaN -> 0x7FC00000
  - inf and inf with opposite effective signs -> 0x7FC00000
  - inf -> inf with its effective sign
  - one zero -> the other operand with its effective sign
  - both zero -> -0 only if both effective signs are negative, else +0
REQ-021 SHALL, in ALIGN, shift B mantissa right one bit per cycle, OR-ing shifted-out bits into S.
  - Duration = max(1, min(d, 27)) cycles, where d = expA-expB.
  - For d>=27, B becomes sticky-only.
REQ-022 SHALL, in COMP, two's-complement B (~B+1, 27 bits) when effective signs differ; otherwise pass B unchanged.
REQ-023 SHALL, in ADD, form a 28-bit sum A+B.
  - For effective subtract, carry-out is discarded.
  - A zero sum -> result +0, next state DONE, skipping NORM/ROUND.
REQ-024 SHALL, in NORM:
  - On carry (bit 27 set), shift right 1 with sticky, exponent+1, taking 1 cycle.
  - Otherwise shift left 1 bit per cycle, exponent-1, until bit 26 is set; this takes max(1, k) cycles.
  - If the exponent reaches 0, result = signed zero, next state DONE.
REQ-025 SHALL, in ROUND, apply round-to-nearest-even on G/R/S.
  - A mantissa carry-out shifts right and increments the exponent in the same cycle.
  - An exponent reaching all-ones -> signed infinity.
REQ-026 SHALL, in DONE, hold result and out_valid stable until out_ready is high; that edge returns to IDLE.
REQ-027 SHALL not accept new operands in the cycle leaving DONE, because in_ready is low in DONE.
REQ-028 SHALL ignore in_valid and operand changes while busy.

Reset
REQ-029 SHALL, while rst_n is low, immediately force:
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - result=0 and all internal registers 0
REQ-030 SHALL abandon any in-flight operation on reset with no output produced, and accept on the first clock edge after rst_n rises.

Verification
REQ-031 SHALL cover add: 0x3F800000 + 0x3F800000, sub=0 -> 0x40000000, with out_valid high exactly 5 edges after the accept edge.
REQ-032 SHALL cover cancellation: 0x3F800000 - 0x3F800000 -> 0x00000000.
REQ-033 SHALL cover rounding:
  - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000.
  - 0x3F800000 + 0x33800001 (above half, via sticky) -> 0x3F800001.
  - 0x40400000 - 0x3F800000 -> 0x40000000, exercising COMP.
REQ-034 SHALL cover overflow: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
REQ-035 SHALL cover special cases:
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000, out_valid 1 edge after accept.
  - 0x7FC00000 + 0x3F800000 -> 0x7FC00000.
REQ-036 SHALL cover backpressure and reset:
  - out_ready low 3 cycles in DONE -> result and out_valid stable, in_ready=0.
  - rst_n low during ALIGN -> out_valid=0, in_ready=1, result=0 immediately.
  - Next operation completes correctly.
